// File: rtl/rx_pkg.sv
// rx_pkg: shared types and helpers for the serial receive frame controller.
// The optional RX_FRAME_PARITY_EN macro adds a parity bit. It widens the
// bit-identification counter by one frame position.
package rx_pkg;

  // Frame controller states. The encoding is fixed at 3 bits so that a
  // debug port can present the state directly.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Width of the bit-sample counter.
  function automatic int bsc_width(input int oversample);
    return (oversample > 2) ? $clog2(oversample) : 1;
  endfunction

  // Width of the bit-identification counter. It must hold the stop-bit index.
  function automatic int bic_width(input int data_bits);
`ifdef RX_FRAME_PARITY_EN
    return $clog2(data_bits + 3);
`else
    return $clog2(data_bits + 2);
`endif
  endfunction

  // bsc value at the mid-point of the start bit.
  function automatic int mid_cmp(input int oversample);
    return oversample / 2 - 1;
  endfunction

  // bsc value at the end of a full bit period.
  function automatic int end_cmp(input int oversample);
    return oversample - 1;
  endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: owns the bit-sample counter (bsc). On sample ticks the
// counter advances toward a compare value. When it reaches that value it
// flags a sample point and wraps to zero. A clear input holds it at zero.
module rx_bit_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_tick,
  input  logic         i_clear,
  input  logic [W-1:0] i_cmp,
  output logic [W-1:0] o_bsc,
  output logic         o_sample_point
);

  logic [W-1:0] r_bsc;
  logic         w_hit;

  assign w_hit          = (r_bsc == i_cmp);
  assign o_sample_point = i_tick & ~i_clear & w_hit;
  assign o_bsc          = r_bsc;

  // Count sample ticks and wrap at the compare value. Clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bsc <= '0;
    end else if (i_clear) begin
      r_bsc <= '0;
    end else if (i_tick) begin
      r_bsc <= w_hit ? '0 : r_bsc + 1'b1;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: serial receive frame controller. It checks the start bit at
// mid-bit and shifts in DATA_BITS data bits, LSB first. It then checks the
// stop bit and either delivers the word or enters BREAK.
// Optional macro RX_FRAME_PARITY_EN adds a parity bit, parameter PARITY_ODD
// and a parity_err pulse.
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int   OVERSAMPLE  = 16,
  parameter int   DATA_BITS   = 8,
  parameter logic START_LEVEL = 1'b1,
`ifdef RX_FRAME_PARITY_EN
  parameter logic PARITY_ODD  = 1'b0,
`endif
  localparam int  BSC_W = bsc_width(OVERSAMPLE),
  localparam int  BIC_W = bic_width(DATA_BITS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 bit_stream,
  output logic                 enable,
  output logic [BSC_W-1:0]     bsc,
  output logic [BIC_W-1:0]     bic,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 framing_err,
`ifdef RX_FRAME_PARITY_EN
  output logic                 parity_err,
`endif
  output rx_state_t            o_state
);

  localparam logic [BSC_W-1:0] MID_CMP       = BSC_W'(mid_cmp(OVERSAMPLE));
  localparam logic [BSC_W-1:0] END_CMP       = BSC_W'(end_cmp(OVERSAMPLE));
  localparam logic [BIC_W-1:0] BIC_LAST_DATA = BIC_W'(DATA_BITS);
`ifdef RX_FRAME_PARITY_EN
  localparam logic [BIC_W-1:0] BIC_STOP      = BIC_W'(DATA_BITS + 2);
`endif

  rx_state_t            r_state;
  logic                 r_enable;
  logic [BIC_W-1:0]     r_bic;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
`ifdef RX_FRAME_PARITY_EN
  logic                 r_perr;
  logic                 r_par_bad;
`endif

  logic                 w_clear;
  logic [BSC_W-1:0]     w_cmp;
  logic                 w_sample;
  logic [BSC_W-1:0]     w_bsc;

  // The timer is idle outside a frame. It samples at mid-bit during START
  // and at the end of each bit for all later frame positions.
  assign w_clear = (r_state == IDLE) || (r_state == BREAK);
  assign w_cmp   = (r_state == START) ? MID_CMP : END_CMP;

  rx_bit_timer #(.W(BSC_W)) u_timer (
    .clk            (clk),
    .rst_n          (reset),
    .i_tick         (sample_tick),
    .i_clear        (w_clear),
    .i_cmp          (w_cmp),
    .o_bsc          (w_bsc),
    .o_sample_point (w_sample)
  );

  assign enable      = r_enable;
  assign bsc         = w_bsc;
  assign bic         = r_bic;
  assign data        = r_data;
  assign data_valid  = r_valid;
  assign framing_err = r_ferr;
`ifdef RX_FRAME_PARITY_EN
  assign parity_err  = r_perr;
`endif
  assign o_state     = r_state;

  // Frame FSM. It also owns bic, the shift register, the output word and
  // the one-clk status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_enable  <= 1'b0;
      r_bic     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef RX_FRAME_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef RX_FRAME_PARITY_EN
      r_perr  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (sample_tick && (bit_stream == START_LEVEL)) begin
            r_state  <= START;
            r_enable <= 1'b1;
            r_bic    <= '0;
          end
        end
        START: begin
          if (w_sample) begin
            if (bit_stream == START_LEVEL) begin
              r_state <= DATA;
              r_bic   <= BIC_W'(1);
            end else begin
              // A short pulse is treated as a glitch. No error is flagged.
              r_state  <= IDLE;
              r_enable <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_sample) begin
            r_shift <= {bit_stream, r_shift[DATA_BITS-1:1]};
            r_bic   <= r_bic + 1'b1;
            if (r_bic == BIC_LAST_DATA) begin
`ifdef RX_FRAME_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
        end
`ifdef RX_FRAME_PARITY_EN
        PARITY: begin
          if (w_sample) begin
            r_par_bad <= ((^r_shift) ^ bit_stream) != PARITY_ODD;
            r_bic     <= BIC_STOP;
            r_state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_sample) begin
            r_enable <= 1'b0;
            r_bic    <= '0;
`ifdef RX_FRAME_PARITY_EN
            r_perr   <= r_par_bad;
`endif
            if (bit_stream != START_LEVEL) begin
              r_state <= IDLE;
`ifdef RX_FRAME_PARITY_EN
              if (!r_par_bad) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end
`else
              r_data  <= r_shift;
              r_valid <= 1'b1;
`endif
            end else begin
              r_ferr  <= 1'b1;
              r_state <= BREAK;
            end
          end
        end
        BREAK: begin
          // Wait for the idle level so a stuck line cannot re-trigger frames.
          if (sample_tick && (bit_stream != START_LEVEL)) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_enable <= 1'b0;
          r_bic    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed frames for rx_frame_ctrl at OVERSAMPLE=16,
// DATA_BITS=8, START_LEVEL=1. Each expected pulse is queued as
// {data_valid, framing_err, parity_err, data}. A negedge monitor pops
// one entry per observed pulse and compares it.
module tb_rx_frame_ctrl;
  import rx_pkg::*;

  localparam logic START_LVL = 1'b1;
  localparam logic IDLE_LVL  = 1'b0;
`ifdef RX_FRAME_PARITY_EN
  localparam int   NBITS     = 11;
  localparam int   BIC_STOP  = 10;
`else
  localparam int   NBITS     = 10;
  localparam int   BIC_STOP  = 9;
`endif
  localparam int   STOP_T    = 8 + 16 * (NBITS - 1);

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       bit_stream;
  logic       enable;
  logic [3:0] bsc;
  logic [3:0] bic;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_err;
  logic       w_perr;
  rx_state_t  o_state;

  logic [10:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  rx_frame_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .bit_stream  (bit_stream),
    .enable      (enable),
    .bsc         (bsc),
    .bic         (bic),
    .data        (data),
    .data_valid  (data_valid),
    .framing_err (framing_err),
`ifdef RX_FRAME_PARITY_EN
    .parity_err  (w_perr),
`endif
    .o_state     (o_state)
  );

`ifndef RX_FRAME_PARITY_EN
  assign w_perr = 1'b0;
`endif

  // ---------------- driver tasks ----------------
  // Apply one sample tick at level b, followed by one tick-free clock.
  task automatic do_tick(input logic b);
    bit_stream  = b;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  // Return the line level at tick t of a frame. Tick 0 is the detection tick.
  function automatic logic frame_level(input int t, input logic [7:0] w,
                                       input logic par, input logic stop);
    int k;
    k = t / 16;
    if (k == 0) return START_LVL;
    if (k <= 8) return w[k-1];
`ifdef RX_FRAME_PARITY_EN
    if (k == 9) return par;
`else
    if (par) return stop;
`endif
    return stop;
  endfunction

  task automatic send_ticks(input logic [7:0] w, input logic par, input logic stop,
                            input int t0, input int t1);
    for (int t = t0; t <= t1; t++) do_tick(frame_level(t, w, par, stop));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [10:0] got;
    logic [10:0] e;
    if (reset === 1'b1 && (data_valid || framing_err || w_perr)) begin
      got = {data_valid, framing_err, w_perr, data};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse got=%h required=none", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL pulse got=%h required=%h", got, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b0;
    sample_tick = 1'b0;
    bit_stream  = IDLE_LVL;
    repeat (3) @(posedge clk);
    #1;
    check("rst_enable", 32'(enable), 0);
    check("rst_bsc", 32'(bsc), 0);
    check("rst_bic", 32'(bic), 0);
    check("rst_data", 32'(data), 0);
    check("rst_pulses", {30'd0, data_valid, framing_err}, 0);
    check("rst_state", 32'(o_state), 32'(IDLE));
    reset = 1'b1;
    @(posedge clk); #1;
    repeat (5) do_tick(IDLE_LVL);
    check("idle_state", 32'(o_state), 32'(IDLE));

    // Good frame 0xA5 (even parity bit 0)
    exp_q.push_back({3'b100, 8'hA5});
    send_ticks(8'hA5, 1'b0, IDLE_LVL, 0, 0);
    check("a5_enable_t0", 32'(enable), 1);
    check("a5_state_t0", 32'(o_state), 32'(START));
    check("a5_bic_t0", 32'(bic), 0);
    send_ticks(8'hA5, 1'b0, IDLE_LVL, 1, 30);
    check("a5_bic_t30", 32'(bic), 2);
    check("a5_bsc_t30", 32'(bsc), 6);
    check("a5_state_t30", 32'(o_state), 32'(DATA));
    send_ticks(8'hA5, 1'b0, IDLE_LVL, 31, STOP_T - 1);
    check("a5_enable_pre_stop", 32'(enable), 1);
    check("a5_state_pre_stop", 32'(o_state), 32'(STOP));
    check("a5_bic_stop", 32'(bic), BIC_STOP);
    send_ticks(8'hA5, 1'b0, IDLE_LVL, STOP_T, STOP_T);
    check("a5_enable_end", 32'(enable), 0);
    check("a5_state_end", 32'(o_state), 32'(IDLE));
    check("a5_data", 32'(data), 32'h A5);

    // Glitch: 4 ticks at start level, then idle
    for (int t = 0; t < 4; t++) do_tick(START_LVL);
    for (int t = 4; t < 8; t++) do_tick(IDLE_LVL);
    check("glitch_enable_t7", 32'(enable), 1);
    do_tick(IDLE_LVL);
    check("glitch_state_t8", 32'(o_state), 32'(IDLE));
    check("glitch_enable_t8", 32'(enable), 0);
    repeat (4) do_tick(IDLE_LVL);

    // Frame 0x3C with a bad stop bit, line held at start level for 40 ticks
    exp_q.push_back({3'b010, 8'hA5});
    send_ticks(8'h3C, 1'b0, START_LVL, 0, STOP_T);
    check("brk_state", 32'(o_state), 32'(BREAK));
    check("brk_enable", 32'(enable), 0);
    check("brk_data", 32'(data), 32'hA5);
    repeat (40) do_tick(START_LVL);
    check("brk_held_state", 32'(o_state), 32'(BREAK));
    check("brk_held_enable", 32'(enable), 0);
    check("brk_held_bsc", 32'(bsc), 0);
    do_tick(IDLE_LVL);
    check("brk_exit_state", 32'(o_state), 32'(IDLE));

    // Back-to-back frames 0x01 (parity 1) then 0xFF (parity 0)
    exp_q.push_back({3'b100, 8'h01});
    exp_q.push_back({3'b100, 8'hFF});
    send_ticks(8'h01, 1'b1, IDLE_LVL, 0, STOP_T);
    check("b2b_data1", 32'(data), 32'h01);
    send_ticks(8'hFF, 1'b0, IDLE_LVL, 0, STOP_T);
    check("b2b_data2", 32'(data), 32'hFF);
    check("b2b_state", 32'(o_state), 32'(IDLE));
    repeat (3) do_tick(IDLE_LVL);

    // Reset in the middle of a frame
    send_ticks(8'hC3, 1'b0, IDLE_LVL, 0, 70);
    check("mid_enable_pre", 32'(enable), 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_enable", 32'(enable), 0);
    check("mid_rst_bsc", 32'(bsc), 0);
    check("mid_rst_bic", 32'(bic), 0);
    check("mid_rst_data", 32'(data), 0);
    check("mid_rst_state", 32'(o_state), 32'(IDLE));
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (20) do_tick(IDLE_LVL);
    check("post_rst_state", 32'(o_state), 32'(IDLE));
    check("post_rst_enable", 32'(enable), 0);
    exp_q.push_back({3'b100, 8'h5A});
    send_ticks(8'h5A, 1'b0, IDLE_LVL, 0, STOP_T);
    check("post_rst_data", 32'(data), 32'h5A);

`ifdef RX_FRAME_PARITY_EN
    // 0x07 has three ones: parity bit 0 is wrong for even parity, 1 is right
    exp_q.push_back({3'b001, 8'h5A});
    send_ticks(8'h07, 1'b0, IDLE_LVL, 0, STOP_T);
    check("par_bad_data", 32'(data), 32'h5A);
    check("par_bad_state", 32'(o_state), 32'(IDLE));
    exp_q.push_back({3'b100, 8'h07});
    send_ticks(8'h07, 1'b1, IDLE_LVL, 0, STOP_T);
    check("par_good_data", 32'(data), 32'h07);
`endif

    // Drain the pipeline and confirm every expected pulse was seen
    repeat (4) do_tick(IDLE_LVL);
    check("exp_q_empty", 32'(exp_q.size()), 0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
Parametrised serial-receive frame controller for the serial-in/parallel-out path. It replaces the separate start-bit enable FSM and its external BIC/BSC counters with one block. The block owns the bit-sample and bit-identification counters, validates the start bit at mid-bit, shifts in a configurable number of data bits, and checks the stop bit. It delivers a parallel word with a one-cycle valid strobe, or raises a framing error and waits for the line to go idle again.

Parameters:
OVERSAMPLE, 16, sample ticks per bit; even, at least 4
DATA_BITS, 8, data bits per frame, 5..9
START_LEVEL, 1, line level of the start bit; idle and stop level is the inverse

Ports:
clk  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
sample_tick  input  1  one-clk oversample strobe; all counting is gated by it
bit_stream  input  1  serial line, already synchronised upstream
enable  output  1  high while a frame is in progress (START..STOP)
bsc  output  $clog2(OVERSAMPLE)  bit-sample counter
bic  output  $clog2(DATA_BITS+2)  bit-identification counter; 0 = start, 1..DATA_BITS = data, DATA_BITS+1 = stop
data  output  DATA_BITS  last good word, LSB received first
data_valid  output  1  one-clk pulse when data updates
framing_err  output  1  one-clk pulse on a bad stop bit

Behaviour:
- Reset (reset=0, async): state=IDLE; enable, bsc, bic, data_valid, framing_err all 0; data=0.
- Outputs are registered. enable is 1 exactly in START, DATA and STOP.
- No counter or state change occurs on cycles without sample_tick, except that the data_valid and framing_err pulses clear on the next clk.
- IDLE: on a tick with bit_stream==START_LEVEL -> START, with bsc=0 and bic=0.
- START: bsc increments on each tick. On the tick where bsc==OVERSAMPLE/2-1, sample the line:
  - still START_LEVEL -> DATA, bsc=0, bic=1.
  - otherwise it is a glitch -> IDLE with no error pulse.
- DATA: bsc increments on each tick. On the tick where bsc==OVERSAMPLE-1, sample the line, shift it into the MSB of the shift register (LSB-first framing), set bsc=0, and increment bic. When bic==DATA_BITS at that sample, go to STOP with bic=DATA_BITS+1.
- STOP: on the tick where bsc==OVERSAMPLE-1, sample the line:
  - equals ~START_LEVEL -> data<=shift register, data_valid=1 next clk, state IDLE.
  - otherwise -> framing_err=1 next clk, data unchanged, state BREAK.
- BREAK: enable=0, counters held at 0. Exit to IDLE only on a tick with bit_stream==~START_LEVEL. This prevents a held-low or held-high line from re-triggering frames.
- Sample points relative to the detection tick: start check at tick OVERSAMPLE/2; data bit i (0-based) at OVERSAMPLE/2+OVERSAMPLE*(i+1); stop bit at OVERSAMPLE/2+OVERSAMPLE*(DATA_BITS+1).
- Back-to-back frames: a start edge on the first tick after returning to IDLE is accepted. No dead tick is required beyond the stop sample.
- data holds its value until the next good frame. There is no consumer handshake; an unread word is simply overwritten.
- Reset mid-frame aborts the frame with no pulse.

Optional Feature:
Macro RX_FRAME_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0) and output parity_err (1-bit, one-clk pulse).
  - Adds a PARITY state between DATA and STOP, sampled at bsc==OVERSAMPLE-1; bic for the parity bit is DATA_BITS+1, and stop becomes DATA_BITS+2. The bic width grows accordingly.
  - Parity mismatch: parity_err pulses when the stop sample is taken, data is not updated, and the state goes to IDLE (or BREAK if the stop bit is also bad, in which case both pulses assert).
- Undefined: no PARITY state, no parity_err port; behaviour exactly as above.

Decomposition:
- Shared package rx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK) with a 3-bit encoding;
  - localparam functions for counter widths;
  - constants for the mid-bit and end-bit compare values.
- One natural sub-module, rx_bit_timer, owns the bsc counter. It takes sample_tick, a clear, and the compare value, and outputs a sample_point strobe. rx_frame_ctrl keeps the FSM, bic and shift register.

Test Plan:
- OVERSAMPLE=16, DATA_BITS=8, START_LEVEL=1, frame 0xA5 with a good stop -> data=8'hA5, data_valid for one clk after detection tick 152, framing_err=0, enable high over detection ticks 1..152.
- A start-level glitch lasting 4 ticks, then idle -> return to IDLE at tick 8, enable falls, no data_valid and no framing_err.
- Frame 0x3C with the stop bit at START_LEVEL, line held there for 40 ticks, then idle -> one framing_err pulse, data keeps its previous value, state stays BREAK for 40 ticks with no new frame, then IDLE.
- Two frames 0x01 then 0xFF back-to-back, with the second start on the first tick after the stop -> two data_valid pulses, data=8'h01 then 8'hFF.
- reset asserted at detection tick 70 of a frame -> all outputs 0 asynchronously. After release, an idle line stays idle and the next frame 0x5A is received correctly.
- With RX_FRAME_PARITY_EN defined and PARITY_ODD=0: 0x07 with parity bit 0 -> parity_err pulse, data unchanged. The same frame with parity bit 1 -> data=8'h07 with data_valid.
